// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command-side controller for the external 8-bit ALU.
// Accepts one command at a time, reads operands from a small register file,
// presents them to the ALU, captures the result, writes it back and returns
// it on a valid/ready response channel.
// Optional build macro: ALU_CMD_SEQUENCER_FLAGS_EN enables the rsp_zero and
// rsp_neg result flags; without it both ports are tied to 0.
module alu_cmd_sequencer #(
  parameter int unsigned NREG    = 4,
  parameter logic [7:0]  RST_VAL = 8'h00,
  localparam int unsigned RW     = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [RW-1:0] cmd_dst,
  input  logic [RW-1:0] cmd_srca,
  input  logic [RW-1:0] cmd_srcb,
  input  logic          cmd_use_imm,
  input  logic [7:0]    cmd_imm,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [2:0]    alu_sel,
  input  logic [7:0]    alu_y,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [7:0]    rsp_data,
  output logic          rsp_err,
  output logic          rsp_zero,
  output logic          rsp_neg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_d;
  logic          accept;
  logic          capture;
  logic          rsp_done;
  logic          legal;
  logic [RW-1:0] dst_q;
  logic [7:0]    rf [NREG];

  // Next-state and per-cycle strobes for the command/response handshake.
  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // alu_sel still holds the latched opcode during ISSUE, so legality is
  // decoded from it rather than from a separate opcode register.
  always_comb begin
    legal = (alu_sel <= 3'd4);
  end

  // State register; cmd_ready is registered and tracks entry into IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
    end else begin
      state     <= state_d;
      cmd_ready <= (state_d == IDLE);
    end
  end

  // Operand/select launch: the register file is read at the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      dst_q   <= '0;
    end else if (accept) begin
      alu_a   <= rf[cmd_srca];
      alu_b   <= cmd_use_imm ? cmd_imm : rf[cmd_srcb];
      alu_sel <= cmd_op;
      dst_q   <= cmd_dst;
    end
  end

  // Register file write-back of legal results at the capture edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        rf[i] <= RST_VAL;
      end
    end else if (capture && legal) begin
      rf[dst_q] <= alu_y;
    end
  end

  // Response registers: loaded at capture, held until the consumer accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_data  <= legal ? alu_y : '0;
      rsp_err   <= ~legal;
    end else if (rsp_done) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_CMD_SEQUENCER_FLAGS_EN
  // Result flags, captured alongside rsp_data; forced low for illegal ops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_zero <= 1'b0;
      rsp_neg  <= 1'b0;
    end else if (capture) begin
      rsp_zero <= legal && (alu_y == 8'h00);
      rsp_neg  <= legal && alu_y[7];
    end
  end
`else
  assign rsp_zero = 1'b0;
  assign rsp_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural model of the
// sibling ALU. Stimulus pushes expected responses; a monitor pops on transfer.
module tb_alu_cmd_sequencer;

  localparam int NREG = 4;
  localparam int RW   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [RW-1:0] cmd_dst;
  logic [RW-1:0] cmd_srca;
  logic [RW-1:0] cmd_srcb;
  logic          cmd_use_imm;
  logic [7:0]    cmd_imm;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [2:0]    alu_sel;
  logic [7:0]    alu_y;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [7:0]    rsp_data;
  logic          rsp_err;
  logic          rsp_zero;
  logic          rsp_neg;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
    logic       zero;
    logic       neg;
  } rsp_t;

  rsp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.NREG(NREG), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
    .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg)
  );

  // Sibling ALU model; illegal selects produce a non-zero junk value.
  always_comb begin
    case (alu_sel)
      3'd0:    alu_y = alu_a + alu_b;
      3'd1:    alu_y = alu_a & alu_b;
      3'd2:    alu_y = alu_a | alu_b;
      3'd3:    alu_y = alu_a ^ alu_b;
      3'd4:    alu_y = ~alu_a;
      default: alu_y = 8'hEE;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rsp_t mk(input logic [7:0] d, input logic e);
    rsp_t r;
    r.data = d;
    r.err  = e;
`ifdef ALU_CMD_SEQUENCER_FLAGS_EN
    r.zero = !e && (d == 8'h00);
    r.neg  = !e && d[7];
`else
    r.zero = 1'b0;
    r.neg  = 1'b0;
`endif
    return r;
  endfunction

  // Called at a negedge; returns at a negedge with cmd_ready high or flags a timeout.
  task automatic wait_ready();
    for (int i = 0; i < 30; i++) begin
      if (cmd_ready) return;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL cmd_ready_timeout: got 0 expected 1");
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                       input logic [1:0] sb, input logic ui, input logic [7:0] imm);
    cmd_op      = op;
    cmd_dst     = dst;
    cmd_srca    = sa;
    cmd_srcb    = sb;
    cmd_use_imm = ui;
    cmd_imm     = imm;
    cmd_valid   = 1'b1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                       input logic [1:0] sb, input logic ui, input logic [7:0] imm);
    wait_ready();
    drive(op, dst, sa, sb, ui, imm);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                      input logic [1:0] sb, input logic ui, input logic [7:0] imm,
                      input logic [7:0] d, input logic e);
    exp_q.push_back(mk(d, e));
    issue(op, dst, sa, sb, ui, imm);
  endtask

  // Monitor: a response transfers at the posedge following a sample with valid&ready.
  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got data %0h err %0b expected none", rsp_data, rsp_err);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_err",  rsp_err,  e.err);
          chk("rsp_zero", rsp_zero, e.zero);
          chk("rsp_neg",  rsp_neg,  e.neg);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_srca = '0;
    cmd_srcb = '0; cmd_use_imm = 1'b0; cmd_imm = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data",  rsp_data, 0);
    chk("rst_rsp_err",   rsp_err, 0);
    chk("rst_rsp_zero",  rsp_zero, 0);
    chk("rst_rsp_neg",   rsp_neg, 0);
    chk("rst_alu_a",     alu_a, 0);
    chk("rst_alu_b",     alu_b, 0);
    chk("rst_alu_sel",   alu_sel, 0);

    // First command with latency/throughput checks: accept edge N.
    send(3'd0, 2'd0, 2'd0, 2'd0, 1'b1, 8'h25, 8'h25, 1'b0);
    chk("issue_rsp_valid", rsp_valid, 0);
    chk("issue_cmd_ready", cmd_ready, 0);
    chk("issue_alu_a",     alu_a, 8'h00);
    chk("issue_alu_b",     alu_b, 8'h25);
    chk("issue_alu_sel",   alu_sel, 3'd0);
    @(negedge clk);
    chk("lat_rsp_valid",   rsp_valid, 1);
    @(negedge clk);
    chk("thru_cmd_ready",  cmd_ready, 1);

    send(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'hDB, 8'h00, 1'b0); // wrap, reg1=00
    send(3'd0, 2'd0, 2'd1, 2'd0, 1'b1, 8'hF0, 8'hF0, 1'b0); // reg0=F0
    send(3'd0, 2'd1, 2'd3, 2'd0, 1'b1, 8'h3C, 8'h3C, 1'b0); // reg1=3C
    send(3'd1, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'h30, 1'b0); // AND
    send(3'd2, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'hFC, 1'b0); // OR
    send(3'd3, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'hCC, 1'b0); // XOR
    send(3'd4, 2'd2, 2'd1, 2'd0, 1'b0, 8'h00, 8'hC3, 1'b0); // NOT ignores B
    send(3'd0, 2'd3, 2'd1, 2'd0, 1'b1, 8'h1E, 8'h5A, 1'b0); // reg3=5A
    send(3'd6, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00, 8'h00, 1'b1); // illegal
    send(3'd0, 2'd0, 2'd3, 2'd0, 1'b1, 8'h00, 8'h5A, 1'b0); // reg3 intact
    send(3'd0, 2'd0, 2'd0, 2'd0, 1'b1, 8'h01, 8'h5B, 1'b0); // dst==srca
    send(3'd0, 2'd1, 2'd0, 2'd1, 1'b0, 8'h00, 8'h97, 1'b0); // dst==srcb, 5B+3C

    // Backpressure: response held, second command must wait.
    wait_ready();
    rsp_ready = 1'b0;
    send(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 8'h60, 1'b0); // reg1=60
    for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_data",  rsp_data, 8'h60);
      chk("hold_rsp_err",   rsp_err, 0);
      chk("hold_cmd_ready", cmd_ready, 0);
      if (i == 0) begin
        exp_q.push_back(mk(8'h9F, 1'b0));
        drive(3'd3, 2'd2, 2'd1, 2'd0, 1'b1, 8'hFF); // 60^FF
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("release_cmd_ready", cmd_ready, 1);
    chk("release_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    chk("second_accepted", cmd_ready, 0);
    cmd_valid = 1'b0;

    // Reset while a command is in ISSUE.
    wait_ready();
    drive(3'd0, 2'd2, 2'd0, 2'd0, 1'b1, 8'h11);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstiss_cmd_ready", cmd_ready, 1);
    chk("rstiss_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", rsp_valid, 0);
      chk("post_rst_cmd_ready", cmd_ready, 1);
    end
    send(3'd0, 2'd0, 2'd2, 2'd0, 1'b1, 8'h00, 8'h00, 1'b0); // reg2 = RST_VAL
    send(3'd0, 2'd1, 2'd1, 2'd0, 1'b1, 8'h07, 8'h07, 1'b0); // reg1 reset too

    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
